// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates at period
// boundaries, optional exact 50% duty for odd divisors, and a per-period tick.
module clk_div_prog #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic             duty50_odd,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_active,
  output logic             upd_pend,
  output logic             load_err
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             duty_q, duty_d;
  logic             pend_duty_q, pend_duty_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             load_err_q, load_err_d;
  logic             neg_q;

  logic             wrap, apply, load_ok, duty_eff;
  logic [DIV_W-1:0] n_eff, half, high;

  always_comb begin
    wrap     = (cnt_q == div_q - DIV_W'(1));
    apply    = en & wrap & pend_q;
    n_eff    = apply ? pend_div_q : div_q;
    duty_eff = apply ? pend_duty_q : duty_q;
    half     = n_eff >> 1;
    // Odd N without exact-duty mode keeps the extra cycle in the high phase.
    high     = (n_eff[0] && !duty_eff) ? half + DIV_W'(1) : half;

    cnt_d  = cnt_q;
    pos_d  = pos_q;
    tick_d = 1'b0;
    div_d  = div_q;
    duty_d = duty_q;
    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + DIV_W'(1);
      pos_d  = (cnt_d < high);
      tick_d = wrap;
      if (apply) begin
        div_d  = pend_div_q;
        duty_d = pend_duty_q;
      end
    end

    // A load landing on the wrap edge is held for the following boundary.
    load_ok     = div_load && (div_val >= MinDiv);
    load_err_d  = div_load && (div_val < MinDiv);
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_duty_d = pend_duty_q;
    if (load_ok) begin
      pend_d      = 1'b1;
      pend_div_d  = div_val;
      pend_duty_d = duty50_odd;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q       <= DefDiv - DIV_W'(1);
      pos_q       <= 1'b0;
      tick_q      <= 1'b0;
      div_q       <= DefDiv;
      duty_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_div_q  <= DefDiv;
      pend_duty_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_duty_q <= pend_duty_d;
      load_err_q  <= load_err_d;
    end
  end

  // Half-cycle delayed copy stretches the high phase by half a period in exact-duty mode.
  always_ff @(negedge clk_in) begin
    neg_q <= pos_q;
  end

  assign clk_out    = pos_q | (duty_q & div_q[0] & neg_q);
  assign tick       = tick_q;
  assign div_active = div_q;
  assign upd_pend   = pend_q;
  assign load_err   = load_err_q;

endmodule
